// File: rtl/majority_voter.sv
// Registered TMR majority voter with a dual-implementation self-check,
// per-channel disagreement flags and saturating disagreement counters.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   x2, x1, x0              redundant input channels, voted per bit
//   clr_cnt                 synchronous clear of all disagreement counters
//   y                       registered majority, sum-of-products form
//   y2                      registered majority, population-count form
//   impl_err                registered flag: y and y2 disagree
//   unanimous               registered flag: all three channels identical
//   ch_fault[2:0]           registered flag per channel: differs from majority
//   fault_cnt0..2           saturating count of cycles each channel was flagged
module majority_voter #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x0,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y2,
    output logic             impl_err,
    output logic             unanimous,
    output logic [2:0]       ch_fault,
    output logic [CNT_W-1:0] fault_cnt0,
    output logic [CNT_W-1:0] fault_cnt1,
    output logic [CNT_W-1:0] fault_cnt2
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] maj_sop_c;
    logic [WIDTH-1:0] maj_pop_c;
    logic [2:0]       ch_fault_c;
    logic             unanimous_c;

    logic [WIDTH-1:0] y_q, y2_q;
    logic             impl_err_q, unanimous_q;
    logic [2:0]       ch_fault_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    // Sum-of-products vote.
    assign maj_sop_c = (x2 & x1) | (x2 & x0) | (x1 & x0);

    // Population-count vote: a 2-bit sum per bit; sum >= 2 is its MSB.
    for (genvar b = 0; b < WIDTH; b++) begin : g_pop
        logic [1:0] sum_c;
        assign sum_c        = 2'({1'b0, x2[b]}) + 2'({1'b0, x1[b]}) + 2'({1'b0, x0[b]});
        assign maj_pop_c[b] = sum_c[1];
    end

    assign ch_fault_c[0] = |(x0 ^ maj_sop_c);
    assign ch_fault_c[1] = |(x1 ^ maj_sop_c);
    assign ch_fault_c[2] = |(x2 ^ maj_sop_c);
    assign unanimous_c   = (x2 == x1) && (x1 == x0);

    // Counter next state: clear wins, otherwise saturating increment.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_cnt) begin
                cnt_d[i] = '0;
            end else if (ch_fault_c[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            y2_q        <= '0;
            impl_err_q  <= 1'b0;
            unanimous_q <= 1'b0;
            ch_fault_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            y_q         <= maj_sop_c;
            y2_q        <= maj_pop_c;
            impl_err_q  <= (maj_sop_c != maj_pop_c);
            unanimous_q <= unanimous_c;
            ch_fault_q  <= ch_fault_c;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign y          = y_q;
    assign y2         = y2_q;
    assign impl_err   = impl_err_q;
    assign unanimous  = unanimous_q;
    assign ch_fault   = ch_fault_q;
    assign fault_cnt0 = cnt_q[0];
    assign fault_cnt1 = cnt_q[1];
    assign fault_cnt2 = cnt_q[2];

endmodule

// File: tb/tb_majority_voter.sv
// Directed bench for majority_voter: a WIDTH=1 instance for the truth table,
// counters, saturation and async reset, and a WIDTH=4 instance for multi-bit voting.
module tb_majority_voter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       x2 = 1'b0, x1 = 1'b0, x0 = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       y, y2, impl_err, unanimous;
    logic [2:0] ch_fault;
    logic [7:0] fault_cnt0, fault_cnt1, fault_cnt2;

    logic [3:0] a2 = 4'd0, a1 = 4'd0, a0 = 4'd0;
    logic [3:0] w_y, w_y2;
    logic       w_impl_err, w_unanimous;
    logic [2:0] w_ch_fault;
    logic [7:0] w_cnt0, w_cnt1, w_cnt2;

    int checks = 0;
    int failures = 0;

    majority_voter #(.WIDTH(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .x2(x2), .x1(x1), .x0(x0), .clr_cnt(clr_cnt),
        .y(y), .y2(y2), .impl_err(impl_err), .unanimous(unanimous), .ch_fault(ch_fault),
        .fault_cnt0(fault_cnt0), .fault_cnt1(fault_cnt1), .fault_cnt2(fault_cnt2)
    );

    majority_voter #(.WIDTH(4), .CNT_W(8)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .x2(a2), .x1(a1), .x0(a0), .clr_cnt(clr_cnt),
        .y(w_y), .y2(w_y2), .impl_err(w_impl_err), .unanimous(w_unanimous), .ch_fault(w_ch_fault),
        .fault_cnt0(w_cnt0), .fault_cnt1(w_cnt1), .fault_cnt2(w_cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        x2 = 1'b1; x1 = 1'b1; x0 = 1'b1;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({y, y2, impl_err, unanimous, ch_fault} !== 7'b0 ||
            fault_cnt0 !== 8'd0 || fault_cnt1 !== 8'd0 || fault_cnt2 !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: y=%b y2=%b ie=%b un=%b chf=%b c0=%0d c1=%0d c2=%0d, expected all 0",
                     y, y2, impl_err, unanimous, ch_fault, fault_cnt0, fault_cnt1, fault_cnt2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (y !== 1'b1 || y2 !== 1'b1 || unanimous !== 1'b1 || ch_fault !== 3'b000) begin
            failures++;
            $display("FAIL first_vote: y=%b y2=%b un=%b chf=%b, expected 1 1 1 000",
                     y, y2, unanimous, ch_fault);
        end
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_y;
        logic [2:0] exp_chf [8];
        exp_y = 8'b1110_1000;  // bit v = expected vote for {x2,x1,x0}=v
        exp_chf[0] = 3'b000; exp_chf[1] = 3'b001; exp_chf[2] = 3'b010; exp_chf[3] = 3'b100;
        exp_chf[4] = 3'b100; exp_chf[5] = 3'b010; exp_chf[6] = 3'b001; exp_chf[7] = 3'b000;
        for (int v = 0; v < 8; v++) begin
            {x2, x1, x0} = 3'(v);
            tick();
            checks++;
            if (y !== exp_y[v] || y2 !== exp_y[v]) begin
                failures++;
                $display("FAIL truth_vote v=%0d: y=%b y2=%b, expected %b", v, y, y2, exp_y[v]);
            end
            checks++;
            if (impl_err !== 1'b0) begin
                failures++;
                $display("FAIL truth_impl_err v=%0d: got %b, expected 0", v, impl_err);
            end
            checks++;
            if (ch_fault !== exp_chf[v]) begin
                failures++;
                $display("FAIL truth_ch_fault v=%0d: got %b, expected %b", v, ch_fault, exp_chf[v]);
            end
            checks++;
            if (unanimous !== (v == 0 || v == 7)) begin
                failures++;
                $display("FAIL truth_unanimous v=%0d: got %b", v, unanimous);
            end
        end
    endtask

    task automatic test_counters();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        {x2, x1, x0} = 3'b110;
        repeat (5) tick();
        checks++;
        if (fault_cnt0 !== 8'd5 || fault_cnt1 !== 8'd0 || fault_cnt2 !== 8'd0) begin
            failures++;
            $display("FAIL count_5: c0=%0d c1=%0d c2=%0d, expected 5 0 0",
                     fault_cnt0, fault_cnt1, fault_cnt2);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (fault_cnt0 !== 8'd0 || ch_fault !== 3'b001) begin
            failures++;
            $display("FAIL clr_priority: c0=%0d chf=%b, expected 0 001", fault_cnt0, ch_fault);
        end
    endtask

    task automatic test_saturation();
        int exp;
        {x2, x1, x0} = 3'b011;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            exp = (i < 255) ? i : 255;
            checks++;
            if (fault_cnt2 !== 8'(exp) || fault_cnt0 !== 8'd0 || fault_cnt1 !== 8'd0) begin
                failures++;
                $display("FAIL saturate cycle=%0d: c2=%0d c0=%0d c1=%0d, expected %0d 0 0",
                         i, fault_cnt2, fault_cnt0, fault_cnt1, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y, y2, impl_err, unanimous, ch_fault} !== 7'b0 ||
            fault_cnt0 !== 8'd0 || fault_cnt1 !== 8'd0 || fault_cnt2 !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: y=%b y2=%b ie=%b un=%b chf=%b c0=%0d c1=%0d c2=%0d, expected all 0",
                     y, y2, impl_err, unanimous, ch_fault, fault_cnt0, fault_cnt1, fault_cnt2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_width4();
        a2 = 4'b1100; a1 = 4'b1010; a0 = 4'b0110;
        tick();
        checks++;
        if (w_y !== 4'b1110 || w_y2 !== 4'b1110) begin
            failures++;
            $display("FAIL w4_vote: y=%b y2=%b, expected 1110", w_y, w_y2);
        end
        checks++;
        if (w_ch_fault !== 3'b111 || w_unanimous !== 1'b0 || w_impl_err !== 1'b0) begin
            failures++;
            $display("FAIL w4_flags: chf=%b un=%b ie=%b, expected 111 0 0",
                     w_ch_fault, w_unanimous, w_impl_err);
        end
        checks++;
        if (w_cnt0 !== 8'd1 || w_cnt1 !== 8'd1 || w_cnt2 !== 8'd1) begin
            failures++;
            $display("FAIL w4_counts: c0=%0d c1=%0d c2=%0d, expected 1 1 1", w_cnt0, w_cnt1, w_cnt2);
        end
        a2 = 4'b0101; a1 = 4'b0101; a0 = 4'b0101;
        tick();
        checks++;
        if (w_y !== 4'b0101 || w_unanimous !== 1'b1 || w_ch_fault !== 3'b000) begin
            failures++;
            $display("FAIL w4_unanimous: y=%b un=%b chf=%b, expected 0101 1 000",
                     w_y, w_unanimous, w_ch_fault);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_counters();
        test_saturation();
        test_async_reset();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/majority_voter.md
Name: majority_voter

Overview:
- Registered triple-modular-redundancy (TMR) voter: three redundant input channels x2, x1, x0 are voted bitwise.
- Result is produced by two independent voting implementations, y and y2, whose agreement is self-checked.
- Also reports which channel disagrees with the majority and keeps saturating per-channel disagreement counters.
- Sits at the output of redundant logic copies, ahead of consumers needing a single fault-masked value.

Parameters:
WIDTH, 1, bit width of each channel; voting is independent per bit.
CNT_W, 8, width of each per-channel disagreement counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
x2  input  WIDTH  redundant channel 2.
x1  input  WIDTH  redundant channel 1.
x0  input  WIDTH  redundant channel 0.
clr_cnt  input  1  synchronous clear of all disagreement counters.
y  output  WIDTH  registered majority, sum-of-products form.
y2  output  WIDTH  registered majority, population-count form.
impl_err  output  1  registered flag: y and y2 implementations disagree.
unanimous  output  1  registered flag: x2 == x1 == x0 on all bits.
ch_fault  output  3  registered per-channel flag; bit i set when channel xi differs from the majority on any bit.
fault_cnt0  output  CNT_W  saturating count of cycles with ch_fault[0] set.
fault_cnt1  output  CNT_W  saturating count of cycles with ch_fault[1] set.
fault_cnt2  output  CNT_W  saturating count of cycles with ch_fault[2] set.

Behaviour:
- Reset values (rst_n low, asynchronous): every output is 0. Reset mid-operation clears all state immediately. The first vote after release samples on the first rising clk edge.
- Latency: every output reflects the inputs sampled at the previous rising edge (1 cycle). No handshake; a new vote is taken every cycle.
- y[b] = (x2[b]&x1[b]) | (x2[b]&x0[b]) | (x1[b]&x0[b]).
- y2[b] = 1 when (x2[b] + x1[b] + x0[b]) >= 2, computed with a 2-bit adder. It must be a structurally separate path from y.
- impl_err = (next y != next y2), registered alongside y. It must always be 0 in fault-free logic.
- unanimous = 1 when all three channels are bit-identical.
- ch_fault[i] = |(xi ^ majority), where majority is the combinational SOP vote of the same cycle.
  - With WIDTH=1, at most one channel is ever flagged.
  - With WIDTH>1, several channels may be flagged, each on different bits.
- Counters:
  - fault_cntN increments by 1 on each edge where the combinational ch_fault[N] is 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - clr_cnt=1 forces all counters to 0 on that edge. clr_cnt has priority over an increment in the same cycle.
  - Counter outputs are the register values, so the count includes the cycle whose fault appears on ch_fault in that same cycle.
- No X propagation is required. Inputs are assumed synchronous to clk.

Test Plan:
1. Reset: hold rst_n=0 with x2,x1,x0=1,1,1 -> all outputs 0. Release and clock once -> y=1, y2=1, unanimous=1, ch_fault=000.
2. Exhaustive truth table, WIDTH=1: drive {x2,x1,x0}=0..7, one value per clock.
   - y and y2 one cycle later = 0,0,0,1,0,1,1,1.
   - impl_err stays 0 throughout.
   - ch_fault = 000,001,010,100,100,010,001,000.
3. Counters: hold {x2,x1,x0}=110 for 5 cycles -> fault_cnt0=5, fault_cnt1=0, fault_cnt2=0. Pulse clr_cnt while input still 110 -> fault_cnt0=0 on that edge.
4. Saturation, CNT_W=8: hold {x2,x1,x0}=011 for 300 cycles -> fault_cnt2=255, stays 255, and never wraps to 0.
5. Asynchronous reset mid-run: assert rst_n low between clock edges while counters are nonzero -> all outputs 0 immediately, without waiting for a clock edge.
6. WIDTH=4: x2=1100, x1=1010, x0=0110 -> y=y2=1110, ch_fault=111 (each channel wrong on one bit), unanimous=0.
